// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// Optional performance counters are enabled by defining FETCH_PERF_EN.
package fetch_pkg;

  localparam int PC_W_DEF    = 8;
  localparam int INSTR_W_DEF = 32;
  localparam int CNT_W_DEF   = 16;

  localparam int          PC_STEP   = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } mode_e;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load a fetched word, hold it, or replace it with a bubble.
// Flush wins over load; with neither asserted the register holds.
module if_id_reg #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ld_i,
  input  logic               flush_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [PC_W-1:0]    pc_i,
  input  logic [INSTR_W-1:0] nop_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc_o,
  output logic               valid_o
);

  logic [INSTR_W-1:0] instr_q;
  logic [PC_W-1:0]    pc_q;
  logic               valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      instr_q <= nop_i;
      pc_q    <= pc_i;
      valid_q <= 1'b0;
    end else if (ld_i) begin
      instr_q <= instr_i;
      pc_q    <= pc_i;
      valid_q <= 1'b1;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: next-PC mux, PC enable, IF/ID mode tracking and perf counters.
// Define FETCH_PERF_EN to build the saturating stall/flush counters; otherwise they read 0.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic [PC_W-1:0]    imem_addr,
  output logic [PC_W-1:0]    next_pc,
  output logic               pc_en,
  output logic [INSTR_W-1:0] id_instr,
  output logic [PC_W-1:0]    id_pc,
  output logic               id_valid,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  mode_e           mode_d, mode_q;
  logic [PC_W-1:0] seq_pc, tgt_pc;
  logic            unused_tgt_lo;

  // Targets are word aligned; the low bits are ignored.
  assign seq_pc        = pc + PC_W'(PC_STEP);
  assign tgt_pc        = {branch_target[PC_W-1:2], 2'b00};
  assign unused_tgt_lo = ^branch_target[1:0];

  assign imem_addr = pc;
  assign next_pc   = branch_taken ? tgt_pc : seq_pc;
  assign pc_en     = !reset && (branch_taken || !stall);

  always_comb begin
    mode_d = FETCH;
    if (branch_taken)  mode_d = FLUSH;
    else if (stall)    mode_d = HOLD;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mode_q <= FETCH;
    else       mode_q <= mode_d;
  end

  if_id_reg #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_if_id (
    .clk     (clk),
    .rst     (reset),
    .ld_i    (mode_d == FETCH),
    .flush_i (mode_d == FLUSH),
    .instr_i (imem_rdata),
    .pc_i    (pc),
    .nop_i   (INSTR_W'(NOP_INSTR)),
    .instr_o (id_instr),
    .pc_o    (id_pc),
    .valid_o (id_valid)
  );

  // A recorded flush always leaves a bubble in ID.
  a_flush_bubble: assert property (@(posedge clk) disable iff (reset)
    (mode_q == FLUSH) |-> !id_valid);

`ifdef FETCH_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (mode_d == HOLD && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (mode_d == FLUSH && flush_cnt_q != '1)
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
